// File: rtl/field_pack_pkg.sv
// Shared types and constants for the field-pack datapath.
// FIELD_PACK_OVERLAP_CHECK_EN is used by the top level (field_pack_arb.sv), not here.
package field_pack_pkg;

  localparam int WORD_W  = 32;
  localparam int FIELD_W = 9;
  localparam int OFF_W   = 5;
  localparam int LEN_W   = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [OFF_W-1:0]   off;
    logic [LEN_W-1:0]   len;
    logic [FIELD_W-1:0] data;
    logic               last;
  } field_req_t;

  // Low-order mask of len ones, widened to the word so it can be shifted into place.
  function automatic logic [WORD_W-1:0] field_mask(input logic [LEN_W-1:0] len);
    return (WORD_W'(1) << len) - WORD_W'(1);
  endfunction

endpackage

// File: rtl/field_pack_rr.sv
// Two-way round-robin arbiter. It turns valid[1:0] plus an enable into a one-hot grant.
// The pointer names the favoured requester and only moves when a grant is issued.
// Every grant is a transfer, because a requester is granted only while it is valid.
module field_pack_rr
  import field_pack_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  // With both requesters valid the pointer breaks the tie.
  // A lone valid requester wins outright.
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (valid_i == 2'b11) begin
        grant_o = ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant_o = valid_i;
      end
    end
  end

  // After a grant, favour whoever did not win. Reset favours requester 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else if (grant_o[0]) begin
      ptr_q <= 1'b1;
    end else if (grant_o[1]) begin
      ptr_q <= 1'b0;
    end
  end

endmodule

// File: rtl/field_pack_arb.sv
// Two-requester field-insert controller. Granted fields are merged into a shadow word,
// which is then handed downstream on a valid/ready handshake.
// Optional feature: define FIELD_PACK_OVERLAP_CHECK_EN to track written bits and pulse ovl_o.
module field_pack_arb
  import field_pack_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [OFF_W-1:0]   req0_off_i,
  input  logic [LEN_W-1:0]   req0_len_i,
  input  logic [FIELD_W-1:0] req0_data_i,
  input  logic               req0_last_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [OFF_W-1:0]   req1_off_i,
  input  logic [LEN_W-1:0]   req1_len_i,
  input  logic [FIELD_W-1:0] req1_data_i,
  input  logic               req1_last_i,
  output logic [WORD_W-1:0]  word_o,
  output logic               word_valid_o,
  input  logic               word_ready_i,
  output logic               err_o,
  output logic               ovl_o
);

  state_t             state_q;
  logic [WORD_W-1:0]  word_q;
  logic               err_q;
  logic [1:0]         grant;
  logic               arb_en;
  logic               xfer;
  field_req_t         req0;
  field_req_t         req1;
  field_req_t         sel;
  logic [OFF_W:0]     field_end;
  logic               bad_range;
  logic [WORD_W-1:0]  place_mask;
  logic [WORD_W-1:0]  place_data;

  assign req0 = '{off: req0_off_i, len: req0_len_i, data: req0_data_i, last: req0_last_i};
  assign req1 = '{off: req1_off_i, len: req1_len_i, data: req1_data_i, last: req1_last_i};

  // Grants are only issued while accumulating and never while reset is asserted.
  assign arb_en = (state_q == ACCUM) && !rst_i;

  field_pack_rr u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (arb_en),
    .valid_i ({req1_valid_i, req0_valid_i}),
    .grant_o (grant)
  );

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];
  assign xfer         = |grant;

  // Select the granted field and work out where it lands.
  // The end position is held one bit wider than the offset, so off+len never wraps.
  always_comb begin
    sel        = grant[1] ? req1 : req0;
    field_end  = {1'b0, sel.off} + {2'b00, sel.len};
    bad_range  = (field_end > (OFF_W+1)'(WORD_W)) || (sel.len > LEN_W'(FIELD_W));
    place_mask = field_mask(sel.len) << sel.off;
    place_data = (({{(WORD_W-FIELD_W){1'b0}}, sel.data} & field_mask(sel.len)) << sel.off);
  end

  // Main sequencer. ACCUM merges granted fields; FLUSH holds the word until the consumer takes it.
  // An out-of-range field is consumed but leaves the word untouched.
  // It still ends the word if it is marked last.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (xfer) begin
            if (bad_range) begin
              err_q <= 1'b1;
            end else begin
              word_q <= (word_q & ~place_mask) | place_data;
            end
            if (sel.last) begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (word_ready_i) begin
            word_q  <= '0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = (state_q == FLUSH);
  assign err_o        = err_q;

`ifdef FIELD_PACK_OVERLAP_CHECK_EN
  logic [WORD_W-1:0] used_q;
  logic              ovl_q;

  // Remember every bit written into the current word and flag a merge that lands on one again.
  // The write itself still goes ahead, so the later field wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      used_q <= '0;
      ovl_q  <= 1'b0;
    end else begin
      ovl_q <= 1'b0;
      if (xfer && !bad_range) begin
        if (|(used_q & place_mask)) begin
          ovl_q <= 1'b1;
        end
        used_q <= used_q | place_mask;
      end else if ((state_q == FLUSH) && word_ready_i) begin
        used_q <= '0;
      end
    end
  end

  assign ovl_o = ovl_q;
`else
  assign ovl_o = 1'b0;
`endif

endmodule

// File: tb/tb_field_pack_arb.sv
// Directed testbench for field_pack_arb. Expected values are worked out by hand from the field layouts.
module tb_field_pack_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req0_ready_o, req0_last_i;
  logic [4:0]  req0_off_i;
  logic [3:0]  req0_len_i;
  logic [8:0]  req0_data_i;
  logic        req1_valid_i, req1_ready_o, req1_last_i;
  logic [4:0]  req1_off_i;
  logic [3:0]  req1_len_i;
  logic [8:0]  req1_data_i;
  logic [31:0] word_o;
  logic        word_valid_o, word_ready_i, err_o, ovl_o;

  int checkCount = 0;
  int passCount  = 0;

`ifdef FIELD_PACK_OVERLAP_CHECK_EN
  localparam logic OVL_EXP = 1'b1;
`else
  localparam logic OVL_EXP = 1'b0;
`endif

  field_pack_arb dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_off_i   (req0_off_i),
    .req0_len_i   (req0_len_i),
    .req0_data_i  (req0_data_i),
    .req0_last_i  (req0_last_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_off_i   (req1_off_i),
    .req1_len_i   (req1_len_i),
    .req1_data_i  (req1_data_i),
    .req1_last_i  (req1_last_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .err_o        (err_o),
    .ovl_o        (ovl_o)
  );

  // Free-running 10-time-unit clock.
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge, so registered outputs are settled.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one requester's request fields.
  task automatic applyStimulus(input int idx, input logic v, input logic [4:0] off,
                               input logic [3:0] len, input logic [8:0] data, input logic last);
    if (idx == 0) begin
      req0_valid_i = v; req0_off_i = off; req0_len_i = len; req0_data_i = data; req0_last_i = last;
    end else begin
      req1_valid_i = v; req1_off_i = off; req1_len_i = len; req1_data_i = data; req1_last_i = last;
    end
  endtask

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Hold reset for two edges with both requesters idle.
  task automatic applyReset();
    applyStimulus(0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);
    applyStimulus(1, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    word_ready_i = 1'b1;
    applyReset();
    checkOutput("reset_word", word_o, 32'h0);
    checkOutput("reset_valid", {31'd0, word_valid_o}, 32'd0);
    checkOutput("reset_err", {31'd0, err_o}, 32'd0);
    checkOutput("reset_ovl", {31'd0, ovl_o}, 32'd0);
    checkOutput("reset_ready", {30'd0, req1_ready_o, req0_ready_o}, 32'd0);

    $display("[TB] single field");
    applyStimulus(0, 1'b1, 5'd24, 4'd8, 9'h0A5, 1'b1);
    #1;
    checkOutput("single_ready", {30'd0, req1_ready_o, req0_ready_o}, 32'd1);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);
    checkOutput("single_word", word_o, 32'hA500_0000);
    checkOutput("single_valid", {31'd0, word_valid_o}, 32'd1);
    tick();
    checkOutput("single_valid_drop", {31'd0, word_valid_o}, 32'd0);
    checkOutput("single_word_clear", word_o, 32'h0);

    $display("[TB] contention and backpressure");
    applyReset();
    word_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 5'd0, 4'd4, 9'h00F, 1'b0);
      applyStimulus(1, 1'b1, 5'd4, 4'd4, 9'h003, (i == 3));
      #1;
      checkOutput($sformatf("contend_grant%0d", i), {30'd0, req1_ready_o, req0_ready_o},
                  (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    checkOutput("contend_word", word_o, 32'h0000_003F);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_valid%0d", i), {31'd0, word_valid_o}, 32'd1);
      checkOutput($sformatf("bp_ready%0d", i), {30'd0, req1_ready_o, req0_ready_o}, 32'd0);
      checkOutput($sformatf("bp_word%0d", i), word_o, 32'h0000_003F);
      tick();
    end
    word_ready_i = 1'b1;
    #1;
    checkOutput("bp_last_word", word_o, 32'h0000_003F);
    tick();
    checkOutput("bp_done_valid", {31'd0, word_valid_o}, 32'd0);
    checkOutput("bp_done_word", word_o, 32'h0);
    checkOutput("bp_ready_back", {30'd0, req1_ready_o, req0_ready_o}, 32'd1);
    applyStimulus(0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);
    applyStimulus(1, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);

    $display("[TB] range errors");
    applyReset();
    applyStimulus(0, 1'b1, 5'd28, 4'd5, 9'h01F, 1'b0);
    #1;
    checkOutput("range_ready", {31'd0, req0_ready_o}, 32'd1);
    tick();
    checkOutput("range_err", {31'd0, err_o}, 32'd1);
    checkOutput("range_word", word_o, 32'h0);
    applyStimulus(0, 1'b1, 5'd0, 4'd10, 9'h1FF, 1'b0);
    tick();
    checkOutput("len_err", {31'd0, err_o}, 32'd1);
    checkOutput("len_word", word_o, 32'h0);
    applyStimulus(0, 1'b1, 5'd23, 4'd9, 9'h1FF, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);
    checkOutput("edge_err", {31'd0, err_o}, 32'd0);
    checkOutput("edge_word", word_o, 32'hFF80_0000);
    checkOutput("edge_valid", {31'd0, word_valid_o}, 32'd1);
    tick();

    $display("[TB] overlap");
    applyReset();
    applyStimulus(0, 1'b1, 5'd8, 4'd8, 9'h0FF, 1'b0);
    tick();
    checkOutput("ovl_first", {31'd0, ovl_o}, 32'd0);
    checkOutput("ovl_first_word", word_o, 32'h0000_FF00);
    applyStimulus(0, 1'b1, 5'd12, 4'd8, 9'h000, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);
    checkOutput("ovl_second", {31'd0, ovl_o}, {31'd0, OVL_EXP});
    checkOutput("ovl_word", word_o, 32'h0000_0F00);
    tick();
    checkOutput("ovl_pulse_end", {31'd0, ovl_o}, 32'd0);

    $display("[TB] reset mid-flush");
    applyReset();
    word_ready_i = 1'b0;
    applyStimulus(0, 1'b1, 5'd0, 4'd4, 9'h005, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);
    checkOutput("mf_valid", {31'd0, word_valid_o}, 32'd1);
    checkOutput("mf_word", word_o, 32'h5);
    rst_i = 1'b1;
    applyStimulus(0, 1'b1, 5'd0, 4'd1, 9'h001, 1'b0);
    applyStimulus(1, 1'b1, 5'd1, 4'd1, 9'h001, 1'b0);
    #1;
    checkOutput("mf_ready_in_rst", {30'd0, req1_ready_o, req0_ready_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    checkOutput("mf_valid_drop", {31'd0, word_valid_o}, 32'd0);
    checkOutput("mf_word_clear", word_o, 32'h0);
    checkOutput("mf_ptr_req0", {30'd0, req1_ready_o, req0_ready_o}, 32'd1);
    applyStimulus(0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);
    applyStimulus(1, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/field_pack_arb.md
# field_pack_arb

Two-requester controller for the 32-bit field-insert datapath. It accepts variable-offset, variable-length field writes from two sources and grants them round-robin. It merges each granted field into a shadow word with an indexed part-select of the form word[off +: len], and hands the finished word downstream on a valid/ready handshake. It sits between the field producers and the word consumer, and owns sequencing and sharing of the part-select write port.

## Interface
- WORD_W, 32, shadow word width; fixed at 32 in this release
- FIELD_W, 9, maximum field length in bits
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req0_valid_i  in  1  requester 0 has a field
- req0_ready_o  out  1  requester 0 granted this cycle
- req0_off_i  in  5  bit offset of field LSB
- req0_len_i  in  4  field length, 0..FIELD_W
- req0_data_i  in  FIELD_W  field value, LSB-aligned
- req0_last_i  in  1  field completes the word
- req1_valid_i, req1_ready_o, req1_off_i, req1_len_i, req1_data_i, req1_last_i: same as requester 0
- word_o  out  WORD_W  merged word
- word_valid_o  out  1  word_o is complete
- word_ready_i  in  1  consumer accepts word
- err_o  out  1  one-cycle pulse: out-of-range field dropped
- ovl_o  out  1  one-cycle pulse: field overlapped already-written bits (see Configuration)

## Operation
- FSM states: ACCUM and FLUSH. Reset state is ACCUM.
- ACCUM:
  - the arbiter grants at most one valid requester per cycle
  - req*_ready_o is high only for the granted requester, and only while rst_i is low
  - a transfer is valid & ready
- Round-robin: with both requesters valid, the priority pointer selects the winner, then moves to the other requester. Reset pointer favours req0. A single valid requester is granted regardless of the pointer.
- Merge on transfer:
  - mask = (1<<len)-1
  - word <= (word & ~(mask<<off)) | ((data & mask)<<off)
  - data bits at or above len are ignored
  - len=0 writes nothing; this is legal, e.g. a pure last-marker
- Range check: if off+len > WORD_W (computed 6 bits wide, no wrap) or len > FIELD_W, the transfer is accepted, the word is unchanged, and err_o pulses.
- If the transfer has last=1, go to FLUSH after the merge. An erroring last transfer still flushes.
- FLUSH:
  - both ready_o are low
  - word_valid_o is high, and word_o is stable until word_ready_i
  - on handshake, the shadow word clears to 0 and the state returns to ACCUM
- Reset mid-word or mid-flush: the partial word is discarded, and word_valid_o drops at the next edge.

## Timing
- Reset values:
  - word_o = 0
  - word_valid_o = 0
  - err_o = 0
  - ovl_o = 0
  - ready_o = 0
  - pointer = req0
- ready_o is combinational from state, the pointer and the valid inputs. There is no input-to-ready registration.
- A merge accepted at edge N is visible on word_o from cycle N+1.
- A last accepted at edge N makes word_valid_o = 1 from cycle N+1. Minimum one-field word latency is 1 cycle.
- err_o and ovl_o are registered: high for exactly cycle N+1.
- A word handshake at edge M gives word_valid_o = 0 and word_o = 0 in cycle M+1. ready_o may reassert in cycle M+1.
- Throughput is one field per cycle in ACCUM, with one bubble cycle minimum per word (FLUSH).

## Configuration
- FIELD_PACK_OVERLAP_CHECK_EN:
  - Defined: a WORD_W-bit written-bit mask is kept per word. It is cleared on reset and on word handshake, and ORed with mask<<off on each valid merge.
  - If a merge intersects the mask, ovl_o pulses. The write still happens and the later field wins.
  - Not defined: no mask register, and ovl_o is tied 0.

## Structure
- Package field_pack_pkg holds:
  - WORD_W, FIELD_W, OFF_W=5, LEN_W=4
  - the state typedef (ACCUM, FLUSH)
  - a field-request struct (off, len, data, last)
- Sub-module field_pack_rr: 2-way round-robin arbiter with a pointer register. It maps valid[1:0] plus an enable to a one-hot grant[1:0], and advances only on transfer.

## Test plan
- Single field: req0 off=24 len=8 data=0xA5 last=1, word_ready_i=1 -> word_o=0xA500_0000, word_valid_o high for 1 cycle, next word starts at 0.
- Contention: both valid every cycle; req0 off=0 len=4 data=0xF, req1 off=4 len=4 data=0x3; req1 last on its 2nd grant -> grants alternate 0,1,0,1; word_o=0x0000_003F.
- Backpressure: last accepted with word_ready_i=0 for 5 cycles -> word_o held, both ready_o low, no new merges; accepted on the 6th cycle.
- Range error: off=28 len=5 data=0x1F -> err_o pulse, word unchanged. Then off=23 len=9 data=0x1FF last=1 -> word_o=0xFF80_0000, no error.
- Overlap (macro defined): off=8 len=8 data=0xFF, then off=12 len=8 data=0x00 last=1 -> ovl_o pulse on the 2nd merge, word_o=0x0000_0F00. With the macro undefined, ovl_o stays 0.
- Reset mid-flush: rst_i high for 1 cycle while word_valid_o=1 -> next cycle word_valid_o=0, word_o=0, pointer=req0.
